// File: rtl/ddr_port_arbiter.sv
// Round-robin burst arbiter that multiplexes NumReq requesters onto one DDR port.
// config_pkg carries the DDR word/address types shared with the memory side.
package config_pkg;
   localparam int DdrAddrWidth = 16;
   localparam int DdrDataWidth = 32;
   typedef logic [DdrAddrWidth-1:0] ddr_address_t;
   typedef logic [DdrDataWidth-1:0] ddr_data_t;
endpackage

module ddr_port_arbiter
   import config_pkg::*;
#(
   parameter int NumReq      = 4,
   parameter int MaxBurst    = 16,
   parameter int ReadLatency = 1
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic [NumReq-1:0]                       req_valid_i,
   output logic [NumReq-1:0]                       req_ready_o,
   input  logic [NumReq-1:0]                       req_write_i,
   input  ddr_address_t [NumReq-1:0]               req_address_i,
   input  logic [NumReq-1:0][$clog2(MaxBurst)-1:0] req_len_i,
   input  ddr_data_t [NumReq-1:0]                  req_w_data_i,
   output logic [NumReq-1:0]                       beat_o,
   output logic [NumReq-1:0]                       r_valid_o,
   output ddr_data_t                               r_data_o,
   output logic [NumReq-1:0]                       done_o,
   output ddr_address_t                            ddr_w_address_o,
   output logic                                    ddr_w_en_o,
   output ddr_data_t                               ddr_w_data_o,
   output ddr_address_t                            ddr_r_address_o,
   output logic                                    ddr_r_en_o,
   input  ddr_data_t                               ddr_r_data_i
);
   localparam int LenW = $clog2(MaxBurst);
   localparam int PtrW = $clog2(NumReq);
   localparam logic [PtrW:0] NumReqW = (PtrW+1)'(NumReq);

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [PtrW-1:0]        owner_q, owner_d;
   logic                   write_q, write_d;
   ddr_address_t           addr_q, addr_d;
   logic [LenW-1:0]        left_q, left_d;
   logic                   done_w_q, done_w_d;
   logic [ReadLatency-1:0] pipe_vld_q, pipe_vld_d;
   logic [ReadLatency-1:0] pipe_last_q, pipe_last_d;

   logic                   live;
   logic                   grant_found;
   logic [PtrW-1:0]        grant_idx, next_ptr;
   logic [PtrW:0]          cand;
   logic                   ready_en, w_en, r_en;
   logic                   pipe_out_vld, pipe_out_last;

   // Outputs are squashed while reset is held so an abandoned burst never leaks a beat.
   assign live          = !rst_i;
   assign pipe_out_vld  = pipe_vld_q[ReadLatency-1];
   assign pipe_out_last = pipe_vld_q[ReadLatency-1] && pipe_last_q[ReadLatency-1];

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = 0; i < NumReq; i++) begin
         cand = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
         if (cand >= NumReqW) cand = cand - NumReqW;
         if (!grant_found && req_valid_i[cand[PtrW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[PtrW-1:0];
         end
      end
      cand = {1'b0, grant_idx} + (PtrW+1)'(1);
      if (cand >= NumReqW) cand = cand - NumReqW;
      next_ptr = cand[PtrW-1:0];
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      write_d  = write_q;
      addr_d   = addr_q;
      left_d   = left_q;
      done_w_d = 1'b0;
      ready_en = 1'b0;
      w_en     = 1'b0;
      r_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (grant_found) begin
               ready_en = 1'b1;
               owner_d  = grant_idx;
               write_d  = req_write_i[grant_idx];
               addr_d   = req_address_i[grant_idx];
               left_d   = req_len_i[grant_idx];
               rr_ptr_d = next_ptr;
               state_d  = BURST;
            end
         end
         BURST: begin
            w_en   = write_q;
            r_en   = !write_q;
            addr_d = addr_q + ddr_address_t'(1);
            left_d = left_q - LenW'(1);
            if (left_q == '0) begin
               state_d  = write_q ? IDLE : DRAIN;
               done_w_d = write_q;
            end
         end
         DRAIN: begin
            if (pipe_out_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Read-latency pipeline: each stage carries "beat issued" and "was the final beat".
   always_comb begin
      pipe_vld_d  = ReadLatency'({pipe_vld_q, r_en});
      pipe_last_d = ReadLatency'({pipe_last_q, r_en && (left_q == '0)});
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         left_q      <= '0;
         done_w_q    <= 1'b0;
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         left_q      <= left_d;
         done_w_q    <= done_w_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_last_q <= pipe_last_d;
      end
   end

   // owner_q still names the finishing requester in the done cycle, even if a new grant happens.
   generate
      for (genvar gi = 0; gi < NumReq; gi++) begin : g_port
         logic is_owner;
         assign is_owner        = (owner_q == PtrW'(gi));
         assign req_ready_o[gi] = live && ready_en && (grant_idx == PtrW'(gi));
         assign beat_o[gi]      = live && w_en && is_owner;
         assign r_valid_o[gi]   = live && pipe_out_vld && is_owner;
         assign done_o[gi]      = live && (done_w_q || pipe_out_last) && is_owner;
      end
   endgenerate

   assign ddr_w_en_o      = live && w_en;
   assign ddr_w_address_o = ddr_w_en_o ? addr_q : '0;
   assign ddr_w_data_o    = ddr_w_en_o ? req_w_data_i[owner_q] : '0;
   assign ddr_r_en_o      = live && r_en;
   assign ddr_r_address_o = ddr_r_en_o ? addr_q : '0;
   assign r_data_o        = (live && pipe_out_vld) ? ddr_r_data_i : '0;

endmodule

// File: doc/ddr_port_arbiter.md
DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 SHALL have parameter NumReq, 4, number of requesters (2..8).
REQ-002 SHALL have parameter MaxBurst, 16, maximum beats per burst (power of two).
REQ-003 SHALL have parameter ReadLatency, 1, cycles from ddr_r_en_o to valid ddr_r_data_i (1..4).
REQ-004 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid_i  input  NumReq  per-requester burst request.
REQ-007 SHALL have port req_ready_o  output  NumReq  one-hot grant pulse; request accepted when valid&&ready.
REQ-008 SHALL have port req_write_i  input  NumReq  1=write burst, 0=read burst.
REQ-009 SHALL have port req_address_i  input  NumReq x ddr_address_t  burst start word address.
REQ-010 SHALL have port req_len_i  input  NumReq x $clog2(MaxBurst)  beats minus one.
REQ-011 SHALL have port req_w_data_i  input  NumReq x ddr_data_t  write data for the current beat.
REQ-012 SHALL have port beat_o  output  NumReq  one-hot; write data of the granted requester consumed this cycle.
REQ-013 SHALL have port r_valid_o  output  NumReq  one-hot read-data-valid.
REQ-014 SHALL have port r_data_o  output  ddr_data_t  read data, shared by all requesters.
REQ-015 SHALL have port done_o  output  NumReq  one-hot pulse, burst fully complete.
REQ-016 SHALL have ports ddr_w_address_o/ddr_w_en_o/ddr_w_data_o and ddr_r_address_o/ddr_r_en_o (outputs), ddr_r_data_i (input), using config_pkg DDR types.

Function
REQ-017 SHALL implement FSM IDLE -> BURST -> (read: DRAIN | write: IDLE) -> IDLE.
REQ-018 In IDLE with any req_valid_i set, SHALL grant in the same cycle the first requester at or after rr_ptr (modulo NumReq), pulse its req_ready_o, latch op/address/len/owner, and go to BURST.
REQ-019 On grant, SHALL set rr_ptr to owner+1 modulo NumReq.
REQ-020 In IDLE with no request, SHALL hold all outputs at 0.
REQ-021 In BURST, SHALL issue exactly one beat per cycle, len+1 beats total, with no bubbles.
REQ-022 Beat k SHALL target the latched address + k, wrapping modulo 2^$bits(ddr_address_t).
REQ-023 On a write beat, SHALL assert ddr_w_en_o, drive req_w_data_i[owner] on ddr_w_data_o, and pulse beat_o[owner] in the same cycle.
REQ-024 On a read beat, SHALL assert ddr_r_en_o and drive ddr_r_address_o.
REQ-025 Each read beat SHALL produce r_valid_o[owner] with r_data_o = ddr_r_data_i exactly ReadLatency cycles after its ddr_r_en_o.
REQ-026 After the last write beat, SHALL pulse done_o[owner] in the next cycle and return to IDLE.
REQ-027 After the last read beat, SHALL enter DRAIN, pulse done_o[owner] in the same cycle as the final r_valid_o, and return to IDLE on the following cycle.
REQ-028 SHALL grant at most one new request per IDLE cycle; the minimum gap between bursts is one IDLE cycle.
REQ-029 SHALL ignore req_* inputs of non-owners during BURST/DRAIN; the owner's req_valid_i is don't-care after the grant.
REQ-030 SHALL never assert ddr_w_en_o and ddr_r_en_o in the same cycle.
REQ-031 SHALL keep req_ready_o, beat_o, r_valid_o and done_o one-hot or zero in every cycle.
REQ-032 len=0 SHALL produce a single beat.
REQ-033 len=MaxBurst-1 SHALL produce MaxBurst beats.

Reset
REQ-034 With rst_i high at a clock edge, SHALL go to IDLE, set rr_ptr to 0, clear the read-latency pipeline, and drive all outputs to 0 on the next cycle.
REQ-035 Reset mid-burst SHALL abandon the burst with no further beats, no r_valid_o, and no done_o.

Verification
REQ-036 Bench SHALL drive req 2 write, addr 0x100, len 3 -> ready_o[2] pulse, then ddr_w_en_o for 4 cycles at 0x100..0x103 with beat_o[2], then done_o[2].
REQ-037 Bench SHALL drive req 0 read, addr 0x20, len 1, ReadLatency=2 -> r_en at 0x20,0x21; r_valid_o[0] 2 cycles after each; done_o[0] with the second.
REQ-038 Bench SHALL hold all four req_valid_i permanently -> grants in order 0,1,2,3,0 and the bus never idles more than 1 cycle between bursts.
REQ-039 Bench SHALL drive a read at addr all-ones, len 2 -> addresses all-ones, 0, 1.
REQ-040 Bench SHALL assert rst_i during beat 2 of a len-7 read -> no further enables, valids or done; rr_ptr=0; a subsequent req 1 is granted normally.
REQ-041 Bench SHALL check that r_en and w_en are never both asserted and that every one-hot output stays one-hot or zero throughout all scenarios.
